// File: rtl/binary_maxpool.sv
// binary_maxpool: reads a binary feature map row pair by row pair, ORs each 2x2 window and
// writes the pooled rows to a separate SRAM region. Optional build macro: MAXPOOL_ODD_PAD_EN.
module binary_maxpool #(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] SRC_BASE = '0,
    parameter logic [ADDR_W-1:0] DST_BASE = 12'h100
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              pool_run,
    input  logic [4:0]        pool_width,
    input  logic [4:0]        pool_rows,
    output logic              pool_busy,
    output logic [ADDR_W-1:0] sram_read_address,
    input  logic [DATA_W-1:0] sram_read_data,
    output logic [ADDR_W-1:0] sram_write_address,
    output logic [DATA_W-1:0] sram_write_data,
    output logic              sram_write_enable
);
    localparam int         OUT_BITS = DATA_W / 2;
    localparam logic [4:0] MAX_W    = 5'(DATA_W);

    typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, GATHER, WRITE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [4:0]        k_reg, k_next;
    logic [4:0]        out_w_reg, out_r_reg;
    logic [DATA_W-1:0] row_a_reg;

    logic [4:0]        width_sat, out_w_in, out_r_in;
    logic [DATA_W-1:0] row_a_in, row_b_in, pooled;
    logic              last_half;

    logic [ADDR_W-1:0] read_address_next, write_address_next;
    logic [DATA_W-1:0] write_data_next;

    assign width_sat = (pool_width > MAX_W) ? MAX_W : pool_width;

`ifdef MAXPOOL_ODD_PAD_EN
    logic [4:0]        width_reg;
    logic              rows_odd_reg;
    logic [DATA_W-1:0] col_mask;

    assign out_w_in = 5'((6'(width_sat) + 6'd1) >> 1);
    assign out_r_in = 5'((6'(pool_rows) + 6'd1) >> 1);

    // Columns beyond the configured width read as zero so a partial window pads with 0.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
            assign col_mask[gi] = (32'(gi) < 32'(width_reg));
        end
    endgenerate

    assign last_half = rows_odd_reg && (k_reg == out_r_reg - 5'd1);
    assign row_a_in  = sram_read_data & col_mask;
    assign row_b_in  = last_half ? '0 : (sram_read_data & col_mask);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            width_reg    <= '0;
            rows_odd_reg <= 1'b0;
        end else if (state_reg == IDLE && pool_run) begin
            width_reg    <= width_sat;
            rows_odd_reg <= pool_rows[0];
        end
    end
`else
    assign out_w_in  = width_sat >> 1;
    assign out_r_in  = pool_rows >> 1;
    assign last_half = 1'b0;
    assign row_a_in  = sram_read_data;
    assign row_b_in  = sram_read_data;
`endif

    // Row B is consumed straight off the read bus on the GATHER->WRITE edge.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pool
            if (gi < OUT_BITS) begin : g_lo
                assign pooled[gi] = (32'(gi) < 32'(out_w_reg)) &
                                    (row_a_reg[2*gi] | row_a_reg[2*gi+1] |
                                     row_b_in[2*gi]  | row_b_in[2*gi+1]);
            end else begin : g_hi
                assign pooled[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        case (state_reg)
            IDLE: begin
                if (pool_run) begin
                    k_next     = '0;
                    state_next = (out_r_in == '0 || out_w_in == '0) ? DONE : ISSUE_A;
                end
            end
            ISSUE_A: state_next = ISSUE_B;
            ISSUE_B: state_next = GATHER;
            GATHER:  state_next = WRITE;
            WRITE: begin
                k_next     = k_reg + 5'd1;
                state_next = ({1'b0, k_reg} + 6'd1 < {1'b0, out_r_reg}) ? ISSUE_A : DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        read_address_next  = sram_read_address;
        write_address_next = sram_write_address;
        write_data_next    = sram_write_data;
        if (state_next == ISSUE_A) begin
            read_address_next = SRC_BASE + ADDR_W'({k_next, 1'b0});
        end else if (state_next == ISSUE_B && !last_half) begin
            read_address_next = SRC_BASE + ADDR_W'({k_next, 1'b1});
        end
        if (state_next == WRITE) begin
            write_address_next = DST_BASE + ADDR_W'(k_next);
            write_data_next    = pooled;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg          <= IDLE;
            k_reg              <= '0;
            out_w_reg          <= '0;
            out_r_reg          <= '0;
            row_a_reg          <= '0;
            pool_busy          <= 1'b0;
            sram_read_address  <= '0;
            sram_write_address <= '0;
            sram_write_data    <= '0;
            sram_write_enable  <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            if (state_reg == IDLE && pool_run) begin
                out_w_reg <= out_w_in;
                out_r_reg <= out_r_in;
            end
            if (state_reg == ISSUE_B) begin
                row_a_reg <= row_a_in;
            end
            pool_busy          <= (state_next != IDLE);
            sram_read_address  <= read_address_next;
            sram_write_address <= write_address_next;
            sram_write_data    <= write_data_next;
            sram_write_enable  <= (state_next == WRITE);
        end
    end

endmodule

// File: tb/tb_binary_maxpool.sv
// Scoreboard bench for binary_maxpool: directed jobs push expected writes and busy lengths,
// independent monitors compare them against what the DUT produces.
module tb_binary_maxpool;
    logic        clk = 1'b0;
    logic        reset_b;
    logic        pool_run;
    logic [4:0]  pool_width;
    logic [4:0]  pool_rows;
    logic        pool_busy;
    logic [11:0] sram_read_address;
    logic [15:0] sram_read_data;
    logic [11:0] sram_write_address;
    logic [15:0] sram_write_data;
    logic        sram_write_enable;

    always #5 clk = ~clk;

    binary_maxpool dut (
        .clk                (clk),
        .reset_b            (reset_b),
        .pool_run           (pool_run),
        .pool_width         (pool_width),
        .pool_rows          (pool_rows),
        .pool_busy          (pool_busy),
        .sram_read_address  (sram_read_address),
        .sram_read_data     (sram_read_data),
        .sram_write_address (sram_write_address),
        .sram_write_data    (sram_write_data),
        .sram_write_enable  (sram_write_enable)
    );

    // Source feature map rows 0..15; one-cycle read latency.
    logic [15:0] mem [0:15];
    always @(posedge clk) begin
        sram_read_data <= (sram_read_address < 12'd16) ? mem[sram_read_address[3:0]] : 16'h0000;
    end

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  busy_q[$];
    int  errors = 0;
    int  checks = 0;
    int  busy_cnt = 0;
    logic busy_prev = 1'b0;
    logic busy_ignore = 1'b0;
    int  max_ra = 0;

    // Write monitor
    always @(negedge clk) begin
        if (sram_write_enable) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%h data=%h (required no write)",
                         sram_write_address, sram_write_data);
            end else begin
                e = exp_q.pop_front();
                if (sram_write_address !== e.addr || sram_write_data !== e.data) begin
                    errors++;
                    $display("FAIL write_data got addr=%h data=%h required addr=%h data=%h",
                             sram_write_address, sram_write_data, e.addr, e.data);
                end else begin
                    $display("write addr=%h data=%h ok", sram_write_address, sram_write_data);
                end
            end
        end
    end

    // Busy-length monitor
    always @(negedge clk) begin
        if (pool_busy) begin
            busy_cnt++;
        end else if (busy_prev) begin
            if (!busy_ignore) begin
                int e;
                checks++;
                if (busy_q.size() == 0) begin
                    errors++;
                    $display("FAIL busy_unexpected got %0d cycles (required no job)", busy_cnt);
                end else begin
                    e = busy_q.pop_front();
                    if (busy_cnt != e) begin
                        errors++;
                        $display("FAIL busy_len got %0d cycles required %0d", busy_cnt, e);
                    end else begin
                        $display("job busy=%0d cycles ok", busy_cnt);
                    end
                end
            end
            busy_cnt = 0;
        end
        busy_prev = pool_busy;
    end

    // Highest read address seen while busy
    always @(negedge clk) begin
        if (pool_busy && int'(sram_read_address) > max_ra) max_ra = int'(sram_read_address);
    end

    task automatic expect_writes(input logic [11:0] base, input int n, input logic [15:0] data);
        for (int i = 0; i < n; i++) exp_q.push_back('{addr: base + 12'(i), data: data});
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (pool_busy !== 1'b0 || sram_write_enable !== 1'b0 || sram_read_address !== 12'h0 ||
            sram_write_address !== 12'h0 || sram_write_data !== 16'h0) begin
            errors++;
            $display("FAIL %s got busy=%b we=%b ra=%h wa=%h wd=%h required all 0", name,
                     pool_busy, sram_write_enable, sram_read_address, sram_write_address,
                     sram_write_data);
        end
    endtask

    task automatic start_job(input logic [4:0] w, input logic [4:0] r);
        @(negedge clk);
        pool_width = w;
        pool_rows  = r;
        pool_run   = 1'b1;
        @(negedge clk);
        pool_run = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (pool_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pool_busy) begin
            errors++;
            $display("FAIL %s_timeout busy=1 after %0d cycles required 0", name, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_write(input string name);
        int n = 0;
        while (!sram_write_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!sram_write_enable) begin
            errors++;
            $display("FAIL %s_nowrite we=0 after %0d cycles required 1", name, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int hi;
        reset_b    = 1'b0;
        pool_run   = 1'b0;
        pool_width = '0;
        pool_rows  = '0;
        fill_mem(16'h0000);
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset_b = 1'b1;

        // Idle with no run
        repeat (20) begin
            @(negedge clk);
            check_zero("idle_no_run");
        end

        // 14x14, single set pixel at row 1 column 3; a second start mid-job is ignored
        mem[1] = 16'h0008;
        exp_q.push_back('{addr: 12'h100, data: 16'h0002});
        expect_writes(12'h101, 6, 16'h0000);
        busy_q.push_back(29);
        start_job(5'd14, 5'd14);
        repeat (5) @(negedge clk);
        pool_width = 5'd16;
        pool_rows  = 5'd2;
        pool_run   = 1'b1;
        @(negedge clk);
        pool_run = 1'b0;
        wait_idle("job14");

        // 16x2 alternating pattern; a pulse during DONE must not restart
        fill_mem(16'h0000);
        mem[0] = 16'hAAAA;
        exp_q.push_back('{addr: 12'h100, data: 16'h00FF});
        busy_q.push_back(5);
        start_job(5'd16, 5'd2);
        wait_write("job16x2");
        @(negedge clk);
        checks++;
        if (pool_busy !== 1'b1) begin
            errors++;
            $display("FAIL done_busy got %b required 1", pool_busy);
        end
        pool_run = 1'b1;
        @(negedge clk);
        pool_run = 1'b0;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (pool_busy) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL done_pulse_ignored busy cycles got %0d required 0", hi);
        end

        // 10x10 all ones
        fill_mem(16'hFFFF);
        expect_writes(12'h100, 5, 16'h001F);
        busy_q.push_back(21);
        start_job(5'd10, 5'd10);
        wait_idle("job10");

        // 9x9 all ones in the valid area: odd width and odd rows
        fill_mem(16'h01FF);
`ifdef MAXPOOL_ODD_PAD_EN
        expect_writes(12'h100, 5, 16'h001F);
        busy_q.push_back(21);
`else
        expect_writes(12'h100, 4, 16'h000F);
        busy_q.push_back(17);
`endif
        @(negedge clk);
        max_ra = 0;
        start_job(5'd9, 5'd9);
        wait_idle("job9");
        checks++;
`ifdef MAXPOOL_ODD_PAD_EN
        if (max_ra != 8) begin
            errors++;
            $display("FAIL job9_max_read got %0d required 8", max_ra);
        end
`else
        if (max_ra != 7) begin
            errors++;
            $display("FAIL job9_max_read got %0d required 7", max_ra);
        end
`endif

        // Single input row
        fill_mem(16'h0000);
        mem[0] = 16'h0003;
`ifdef MAXPOOL_ODD_PAD_EN
        exp_q.push_back('{addr: 12'h100, data: 16'h0001});
        busy_q.push_back(5);
`else
        busy_q.push_back(1);
`endif
        start_job(5'd16, 5'd1);
        wait_idle("rows1");

        // Zero width
        busy_q.push_back(1);
        start_job(5'd0, 5'd4);
        wait_idle("width0");

        // Width above 16 saturates
        mem[0] = 16'h8001;
        mem[1] = 16'h0000;
        exp_q.push_back('{addr: 12'h100, data: 16'h0081});
        busy_q.push_back(5);
        start_job(5'd31, 5'd2);
        wait_idle("width31");

        // Reset asserted during GATHER of the second window
        fill_mem(16'h0000);
        mem[1] = 16'h0008;
        exp_q.push_back('{addr: 12'h100, data: 16'h0002});
        start_job(5'd14, 5'd14);
        wait_write("reset_job");
        repeat (3) @(posedge clk);
        #1;
        busy_ignore = 1'b1;
        reset_b     = 1'b0;
        #1;
        check_zero("reset_gather_immediate");
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_gather_hold");
        end
        reset_b = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_zero("after_reset_idle");
        end
        busy_ignore = 1'b0;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL writes_missing got %0d outstanding required 0", exp_q.size());
        end
        checks++;
        if (busy_q.size() != 0) begin
            errors++;
            $display("FAIL jobs_missing got %0d outstanding required 0", busy_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
